fir_out_requant: RTL and testbench
==================================

# fir_out_requant

Output stage placed directly downstream of the tapped-delay FIR filter. It captures the filter's full-precision 2N-bit signed result on every enabled sample cycle and rounds and rescales it by a programmable right shift. It then saturates the result to N bits, optionally decimates, and buffers the kept samples in a small FIFO. The FIFO drains through a valid/ready handshake to the consumer.

## Interface

Parameters:
- N, 16, output sample width; input width is 2N.
- DEPTH, 8, FIFO depth in samples; power of two, ≥2.
- SW, $clog2(2N) (5 for N=16), width of the shift port.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- ena  input  1  sample strobe, same signal that advances the FIR.
- y_in  input  2N  signed FIR output, combinational from the FIR registers.
- shift  input  SW  arithmetic right-shift amount, 0..2N-1.
- decim  input  8  decimation: keep 1 of every decim+1 samples.
- clr  input  1  synchronous clear of sat_seen and drop_cnt.
- y_out  output  N  signed FIFO head sample; 0 when FIFO is empty.
- y_valid  output  1  FIFO not empty.
- y_ready  input  1  consumer accepts the head sample when y_valid=1.
- sat_seen  output  1  sticky flag: a kept sample was saturated.
- drop_cnt  output  8  saturating count of samples dropped because the FIFO was full.

## Operation

**Capture.** On a rising edge with ena=1, y_in is one sample. With ena=0 nothing is captured. The pipeline and the handshake keep running regardless of ena.

**Decimation.** An 8-bit counter dcnt:
- The sample is kept when dcnt==0.
- dcnt increments on every captured sample.
- dcnt wraps to 0 after reaching decim.
- If decim is lowered so that dcnt>decim, the next captured sample sets dcnt to 0 and is not kept.
- decim=0 keeps every sample.

**Stage 1 (registered), kept samples only.**
- Compute r = (y_in + (shift>0 ? 2^(shift-1) : 0)) >>> shift in 2N+1 bits.
- This is round-half-up toward +inf, with no wrap on the addition.
- Register r together with a valid bit.

**Stage 2 (registered).**
- Saturate r to [-2^(N-1), 2^(N-1)-1].
- Set sat_seen if clamping occurred.
- Write the result into the FIFO.

**FIFO.**
- Show-ahead: y_out = mem[rd_ptr] when non-empty.
- Pop occurs on an edge where y_valid & y_ready.
- Write when full with no pop in the same cycle: the new sample is discarded, FIFO contents are unchanged, and drop_cnt increments, saturating at 255.
- Write when full with a pop in the same cycle: both succeed, and occupancy stays at DEPTH.
- Write when empty: y_valid rises on the edge after the write. A same-cycle pop is impossible because y_valid=0.
- Pointers have log2(DEPTH)+1 bits; they wrap naturally.

**clr.** Zeroes sat_seen and drop_cnt. If a saturation or drop event occurs in the same cycle, the event wins: the flag ends at 1, or the count ends at 1.

## Timing

- **Reset (asynchronous).**
  - Pipeline valids, dcnt and FIFO pointers go to 0; the FIFO is empty.
  - y_valid=0, y_out=0, sat_seen=0, drop_cnt=0.
  - Samples in flight or buffered are lost.
  - After release, the first ena=1 edge is a kept sample.
- **Latency.** A sample captured at edge k is in stage 1 after k, written to the FIFO at k+1, and y_valid=1 after k+1 (if the FIFO was empty).
- **Throughput.** One sample per cycle sustained with decim=0, ena=1 and y_ready=1.
- **Control sampling.** shift and decim are sampled at the capture edge and must be stable in that cycle. Changing them affects only later samples.
- **Stability.** y_out and y_valid change only after a clock edge, never combinationally from y_ready.

## Test plan

1. Pass-through: reset, then shift=0, decim=0, y_ready=1, ena=1 for one cycle, y_in=100 → y_valid=1 and y_out=100 two edges later; pops next edge; sat_seen=0.
2. Rounding: shift=4.
   - y_in=24 → y_out=2.
   - y_in=-24 → y_out=-1.
   - y_in=7 → y_out=0.
   - y_in=8 → y_out=1.
3. Saturation: shift=0.
   - y_in=0x00012345 → y_out=0x7FFF and sat_seen=1.
   - y_in=-70000 → y_out=0x8000.
   - Pulse clr → sat_seen=0.
   - clr in the same cycle as a saturating write → sat_seen stays 1.
4. Decimation: decim=2, ena=1 continuously, y_in=1..9 → outputs exactly 1, 4, 7. With ena toggling 1/0 the same outputs result, with only ena=1 cycles counted.
5. Overflow: DEPTH=8, y_ready=0, push 10 samples of values 1..10 → y_valid=1, drop_cnt=2; then y_ready=1 drains 1..8 in order, then y_valid=0. Push-with-pop while full → no drop.
6. Reset mid-operation: FIFO holding 5 samples and stage 1 valid; assert rst asynchronously between edges → y_valid=0, y_out=0 and drop_cnt=0 immediately. After release, nothing emerges until new samples are captured.

Source files
------------

// File: rtl/fir_out_requant.sv
// Output stage for the tapped-delay FIR. It rounds and shifts the full-precision result,
// saturates it to N bits, optionally decimates, and buffers samples in a show-ahead FIFO.
module fir_out_requant #(
  parameter int N     = 16,
  parameter int DEPTH = 8,
  parameter int SW    = $clog2(2*N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [2*N-1:0] y_in,
  input  logic [SW-1:0]  shift,
  input  logic [7:0]     decim,
  input  logic           clr,
  output logic [N-1:0]   y_out,
  output logic           y_valid,
  input  logic           y_ready,
  output logic           sat_seen,
  output logic [7:0]     drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int W1 = 2*N + 1;

  logic [7:0]           r_dcnt;
  logic                 r_s1_valid;
  logic signed [W1-1:0] r_s1;
  logic [N-1:0]         r_mem [DEPTH];
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic                 r_sat_seen;
  logic [7:0]           r_drop_cnt;

  logic                 w_keep;
  logic signed [W1-1:0] w_ext;
  logic signed [W1-1:0] w_round;
  logic signed [W1-1:0] w_sum;
  logic signed [W1-1:0] w_shifted;
  logic                 w_sat_hi;
  logic                 w_sat_lo;
  logic                 w_sat;
  logic [N-1:0]         w_sat_val;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;

  assign w_keep = ena && (r_dcnt == 8'd0);

  // One extra bit keeps the rounding addition from wrapping at the positive extreme.
  assign w_ext     = {y_in[2*N-1], y_in};
  assign w_round   = (shift != '0) ? (W1'(1) << (shift - SW'(1))) : '0;
  assign w_sum     = w_ext + w_round;
  assign w_shifted = w_sum >>> shift;

  // Out of range whenever the bits above the N-bit sign position disagree with the sign.
  assign w_sat_hi  = !r_s1[W1-1] && (|r_s1[W1-2:N-1]);
  assign w_sat_lo  =  r_s1[W1-1] && !(&r_s1[W1-2:N-1]);
  assign w_sat     = w_sat_hi || w_sat_lo;
  assign w_sat_val = w_sat_hi ? {1'b0, {(N-1){1'b1}}} :
                     w_sat_lo ? {1'b1, {(N-1){1'b0}}} : r_s1[N-1:0];

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = y_valid && y_ready;
  assign w_push  = r_s1_valid && (!w_full || w_pop);
  assign w_drop  = r_s1_valid && w_full && !w_pop;

  assign y_valid  = !w_empty;
  assign y_out    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign sat_seen = r_sat_seen;
  assign drop_cnt = r_drop_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dcnt     <= '0;
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else begin
      if (ena) r_dcnt <= (r_dcnt >= decim) ? 8'd0 : r_dcnt + 8'd1;
      r_s1_valid <= w_keep;
      if (w_keep) r_s1 <= w_shifted;
    end
  end

  // NOTE: storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_sat_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // A same-cycle event beats clr: the flag stays set and the count restarts at one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sat_seen <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (r_s1_valid && w_sat) r_sat_seen <= 1'b1;
      else if (clr)            r_sat_seen <= 1'b0;

      if (w_drop)   r_drop_cnt <= clr ? 8'd1 :
                                  (r_drop_cnt == 8'hFF) ? 8'hFF : r_drop_cnt + 8'd1;
      else if (clr) r_drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_fir_out_requant.sv
// Scoreboard bench for fir_out_requant: expected samples are queued at drive time and
// compared whenever the DUT hands a sample to the consumer.
module tb_fir_out_requant;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic [31:0] y_in = '0;
  logic [4:0]  shift = '0;
  logic [7:0]  decim = '0;
  logic        clr = 1'b0;
  logic [15:0] y_out;
  logic        y_valid;
  logic        y_ready = 1'b0;
  logic        sat_seen;
  logic [7:0]  drop_cnt;

  int          n_chk = 0;
  int          n_err = 0;
  int          m_dcnt = 0;
  logic [15:0] q[$];

  fir_out_requant #(.N(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .y_in(y_in), .shift(shift), .decim(decim),
    .clr(clr), .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready),
    .sat_seen(sat_seen), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: round half up, arithmetic shift, clamp to 16-bit signed.
  function automatic logic [15:0] requant(input logic [31:0] y, input int sh);
    longint v;
    v = longint'($signed(y));
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // accept=0 marks a kept sample that the FIFO is expected to discard.
  task automatic drive(input logic [31:0] y, input bit accept);
    ena  = 1'b1;
    y_in = y;
    if (m_dcnt == 0 && accept) q.push_back(requant(y, int'(shift)));
    m_dcnt = (m_dcnt >= int'(decim)) ? 0 : m_dcnt + 1;
    tick();
    ena = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    y_ready = 1'b1;
    while ((q.size() != 0 || y_valid) && cyc < 300) begin
      tick();
      cyc++;
    end
    if (cyc >= 300) check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst && y_valid && y_ready) begin
      if (q.size() == 0) check("pop_unexpected", 32'(y_valid), 32'd0);
      else               check("pop_value", 32'(y_out), 32'(q.pop_front()));
    end
  end

  initial begin
    // Reset state
    idle(2);
    check("rst_valid", 32'(y_valid), 32'd0);
    check("rst_yout", 32'(y_out), 32'd0);
    check("rst_sat", 32'(sat_seen), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b1;
    idle(1);

    // Pass-through and latency
    y_ready = 1'b1;
    drive(32'd100, 1'b1);
    check("lat_not_yet", 32'(y_valid), 32'd0);
    tick();
    check("lat_valid", 32'(y_valid), 32'd1);
    check("lat_value", 32'(y_out), 32'd100);
    tick();
    check("lat_popped", 32'(y_valid), 32'd0);
    check("empty_yout", 32'(y_out), 32'd0);
    check("pass_sat", 32'(sat_seen), 32'd0);

    // Rounding, including the widest shift at both input extremes
    shift = 5'd4;
    drive(32'd24, 1'b1);
    drive(-32'sd24, 1'b1);
    drive(32'd7, 1'b1);
    drive(32'd8, 1'b1);
    drive(-32'sd8, 1'b1);
    shift = 5'd31;
    drive(32'h7FFF_FFFF, 1'b1);
    drive(32'h8000_0000, 1'b1);
    drain();
    check("round_no_sat", 32'(sat_seen), 32'd0);

    // Saturation and sticky flag with clr
    shift = 5'd0;
    drive(32'h0001_2345, 1'b1);
    idle(1);
    check("sat_pos_flag", 32'(sat_seen), 32'd1);
    drive(-32'sd70000, 1'b1);
    drain();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("sat_clr", 32'(sat_seen), 32'd0);
    drive(32'd32767, 1'b1);
    drive(-32'sd32768, 1'b1);
    drain();
    check("sat_edge_none", 32'(sat_seen), 32'd0);
    drive(32'h0010_0000, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("sat_clr_race", 32'(sat_seen), 32'd1);
    drain();

    // Decimation: continuous, then with ena gaps, then lowering decim mid-count
    decim = 8'd2;
    for (int i = 1; i <= 9; i++) drive(32'(i), 1'b1);
    drain();
    for (int i = 1; i <= 9; i++) begin
      drive(32'(i), 1'b1);
      idle(1);
    end
    drain();
    decim = 8'd5;
    for (int i = 10; i <= 12; i++) drive(32'(i), 1'b1);
    decim = 8'd1;
    for (int i = 13; i <= 16; i++) drive(32'(i), 1'b1);
    decim = 8'd0;
    drive(32'd17, 1'b1);
    drive(32'd18, 1'b1);
    drain();

    // Overflow: 10 into 8 slots
    y_ready = 1'b0;
    for (int i = 1; i <= 10; i++) drive(32'(i), i <= 8);
    idle(3);
    check("ovf_valid", 32'(y_valid), 32'd1);
    check("ovf_head", 32'(y_out), 32'd1);
    check("ovf_drops", 32'(drop_cnt), 32'd2);
    drain();
    check("ovf_empty", 32'(y_valid), 32'd0);

    // Write while full with a simultaneous pop
    y_ready = 1'b0;
    for (int i = 11; i <= 18; i++) drive(32'(i), 1'b1);
    idle(3);
    drive(32'd19, 1'b1);
    y_ready = 1'b1;
    tick();
    check("full_pushpop_drop", 32'(drop_cnt), 32'd2);
    drain();

    // Drop counter saturation and clr interaction
    y_ready = 1'b0;
    for (int i = 0; i < 268; i++) drive(32'(i), i < 8);
    idle(3);
    check("drop_sat", 32'(drop_cnt), 32'd255);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("drop_clr", 32'(drop_cnt), 32'd0);
    drive(32'd500, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("drop_clr_race", 32'(drop_cnt), 32'd1);
    drain();

    // Asynchronous reset with FIFO holding 5 and stage 1 busy
    y_ready = 1'b0;
    for (int i = 40; i < 46; i++) drive(32'(i), 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(y_valid), 32'd0);
    check("arst_yout", 32'(y_out), 32'd0);
    check("arst_drop", 32'(drop_cnt), 32'd0);
    check("arst_sat", 32'(sat_seen), 32'd0);
    q.delete();
    m_dcnt = 0;
    idle(2);
    #3;
    rst = 1'b1;
    y_ready = 1'b1;
    idle(5);
    check("post_rst_idle", 32'(y_valid), 32'd0);
    decim = 8'd2;
    drive(32'd77, 1'b1);
    drive(32'd78, 1'b1);
    drain();
    check("post_rst_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
